// File: rtl/vdp_bus_pkg.sv
// Shared types for the VDP host bus front end: FSM states, strobe kinds, address width.
package vdp_bus_pkg;

  localparam int VDP_ADR_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_ISSUE, ST_HOLD} bus_state_t;
  typedef enum logic [1:0] {K_NONE, K_RD, K_WR, K_BOTH} bus_kind_t;

  // Strobes are active low: a single low strobe selects the access kind.
  function automatic bus_kind_t decode_kind(input logic csr_n_s, input logic csw_n_s);
    bus_kind_t k;
    case ({csr_n_s, csw_n_s})
      2'b01:   k = K_RD;
      2'b10:   k = K_WR;
      2'b00:   k = K_BOTH;
      default: k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// N-flop synchroniser bringing an asynchronous bus into clk_w; reset value set per instance.
module bus_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_w,
  input  logic             reset_n_w,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RST_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vdp_cpu_bus_if.sv
// Host-side VDP I/O port front end: synchronises and glitch-filters MSX strobes and
// issues one registered request per qualified access; holds read data on cdi.
module vdp_cpu_bus_if
  import vdp_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int RD_LAT      = 2
) (
  input  logic                 clk_w,
  input  logic                 reset_n_w,
  input  logic                 csr_n,
  input  logic                 csw_n,
  input  logic [1:0]           mode,
  input  logic [7:0]           cdo,
  input  logic [7:0]           vdp_dbi,
  output logic                 cpu_req,
  output logic                 cpu_wrt,
  output logic [VDP_ADR_W-1:0] cpu_adr,
  output logic [7:0]           cpu_dbo,
  output logic [7:0]           cdi,
  output logic                 busy,
  output logic                 proto_err,
  output bus_state_t           state_dbg
);

  // cpu_req is a one-cycle valid with no ready: the core must take it in the cycle it is
  // high; cpu_wrt is meaningful only then, cpu_adr/cpu_dbo hold until the next access.

  localparam int             CW        = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0]  FILT_LAST = CW'(FILT_CYCLES - 1);

  logic [1:0]  strb_s;
  logic [9:0]  data_s;
  logic [1:0]  mode_s;
  logic [7:0]  cdo_s;
  bus_kind_t   kind;

  bus_state_t  state, state_nx;
  bus_kind_t   kind_l, kind_l_nx;
  logic [CW-1:0] filt_cnt, filt_nx;
  logic [CW-1:0] rel_cnt, rel_nx;
  logic [CW-1:0] both_cnt;
  logic [RD_LAT-1:0] rd_sr;
  logic        take;
  logic        rd_issue;

  bus_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_sync_strb (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .d         ({csr_n, csw_n}),
    .q         (strb_s)
  );

  bus_sync #(.WIDTH(10), .STAGES(SYNC_STAGES), .RST_VAL(10'd0)) u_sync_data (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .d         ({mode, cdo}),
    .q         (data_s)
  );

  assign mode_s = data_s[9:8];
  assign cdo_s  = data_s[7:0];
  assign kind   = decode_kind(strb_s[1], strb_s[0]);

  // BOTH never qualifies an access; it only differs from kind_l, so it acts as a release.
  always_comb begin
    state_nx  = state;
    kind_l_nx = kind_l;
    filt_nx   = filt_cnt;
    rel_nx    = rel_cnt;
    take      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (kind == K_RD || kind == K_WR) begin
          kind_l_nx = kind;
          if (FILT_CYCLES == 1) begin
            state_nx = ST_ISSUE;
            take     = 1'b1;
          end else begin
            state_nx = ST_QUAL;
            filt_nx  = CW'(1);
          end
        end
      end
      ST_QUAL: begin
        if (kind != kind_l) begin
          state_nx = ST_IDLE;
        end else if (filt_cnt == FILT_LAST) begin
          state_nx = ST_ISSUE;
          take     = 1'b1;
        end else begin
          filt_nx = filt_cnt + CW'(1);
        end
      end
      ST_ISSUE: begin
        state_nx = ST_HOLD;
        rel_nx   = '0;
      end
      ST_HOLD: begin
        if (kind == kind_l) begin
          rel_nx = '0;
        end else if (rel_cnt == FILT_LAST) begin
          state_nx = ST_IDLE;
          rel_nx   = '0;
        end else begin
          rel_nx = rel_cnt + CW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rd_issue = take && (kind_l_nx == K_RD);

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state    <= ST_IDLE;
      kind_l   <= K_NONE;
      filt_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_nx;
      kind_l   <= kind_l_nx;
      filt_cnt <= filt_nx;
      rel_cnt  <= rel_nx;
    end
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      cpu_req   <= 1'b0;
      cpu_wrt   <= 1'b0;
      cpu_adr   <= '0;
      cpu_dbo   <= '0;
      rd_sr     <= '0;
      cdi       <= 8'hFF;
      both_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      cpu_req <= take;
      cpu_wrt <= take && (kind_l_nx == K_WR);
      if (take) begin
        cpu_adr <= {{(VDP_ADR_W-2){1'b0}}, mode_s};
        cpu_dbo <= cdo_s;
      end
      // A fresh read pulse restarts the capture window.
      rd_sr <= rd_issue ? RD_LAT'(1) : (rd_sr << 1);
      if (rd_sr[RD_LAT-1]) cdi <= vdp_dbi;
      if (kind != K_BOTH) begin
        both_cnt <= '0;
      end else if (both_cnt == FILT_LAST) begin
        proto_err <= 1'b1;
      end else begin
        both_cnt <= both_cnt + CW'(1);
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_vdp_cpu_bus_if.sv
// Bench for vdp_cpu_bus_if: directed host accesses plus random strobe traffic,
// checked every cycle against a run-length model of the host access rules.
module tb_vdp_cpu_bus_if;

  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int RDL  = 2;
  localparam int KN = 0, KR = 1, KW = 2, KB = 3;

  logic        clk_w = 1'b0;
  logic        reset_n_w;
  logic        csr_n, csw_n;
  logic [1:0]  mode;
  logic [7:0]  cdo, vdp_dbi;
  logic        cpu_req, cpu_wrt, busy, proto_err;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dbo, cdi;
  vdp_bus_pkg::bus_state_t state_dbg;

  vdp_cpu_bus_if #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .RD_LAT(RDL)) dut (
    .clk_w     (clk_w),
    .reset_n_w (reset_n_w),
    .csr_n     (csr_n),
    .csw_n     (csw_n),
    .mode      (mode),
    .cdo       (cdo),
    .vdp_dbi   (vdp_dbi),
    .cpu_req   (cpu_req),
    .cpu_wrt   (cpu_wrt),
    .cpu_adr   (cpu_adr),
    .cpu_dbo   (cpu_dbo),
    .cdi       (cdi),
    .busy      (busy),
    .proto_err (proto_err),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk_w = ~clk_w;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int pulse_cnt = 0;
  int last_req_edge = -100;
  bit busy_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Reference model: pin samples delayed by SYNC edges, then run-length rules.
  int         hq_kind[$];
  logic [1:0] hq_mode[$];
  logic [7:0] hq_cdo[$];
  int         m_run, m_rk, m_ak, m_rel, m_both, m_cap;
  bit         m_acc, m_skip;
  logic       m_req, m_wrt, m_perr, m_busy;
  logic [1:0] m_adr;
  logic [7:0] m_dbo, m_cdi;
  logic [10:0] exp_q[$];

  function automatic int pin_kind(input logic r_n, input logic w_n);
    if (!r_n && !w_n) return KB;
    if (!r_n) return KR;
    if (!w_n) return KW;
    return KN;
  endfunction

  task automatic model_reset();
    hq_kind.delete(); hq_mode.delete(); hq_cdo.delete();
    for (int i = 0; i < SYNC; i++) begin
      hq_kind.push_back(KN); hq_mode.push_back(2'd0); hq_cdo.push_back(8'd0);
    end
    m_run = 0; m_rk = KN; m_ak = KN; m_rel = 0; m_both = 0; m_cap = 0;
    m_acc = 1'b0; m_skip = 1'b0;
    m_req = 1'b0; m_wrt = 1'b0; m_perr = 1'b0; m_busy = 1'b0;
    m_adr = 2'd0; m_dbo = 8'd0; m_cdi = 8'hFF;
    exp_q.delete();
  endtask

  task automatic model_step(input int pk, input logic [1:0] pm, input logic [7:0] pd,
                            input logic [7:0] dbi);
    int s;
    logic [1:0] sm;
    logic [7:0] sd;
    s  = hq_kind.pop_front();
    sm = hq_mode.pop_front();
    sd = hq_cdo.pop_front();
    hq_kind.push_back(pk); hq_mode.push_back(pm); hq_cdo.push_back(pd);
    m_req = 1'b0;
    m_wrt = 1'b0;
    if (m_cap > 0) begin
      m_cap--;
      if (m_cap == 0) m_cdi = dbi;
    end
    if (s == KB) begin
      m_both++;
      if (m_both >= FILT) m_perr = 1'b1;
    end else begin
      m_both = 0;
    end
    if (m_acc) begin
      // the cycle right after the pulse does not count towards release
      if (m_skip) m_skip = 1'b0;
      else if (s == m_ak) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == FILT) begin m_acc = 1'b0; m_run = 0; end
      end
    end else if (m_run == 0) begin
      if (s == KR || s == KW) begin m_rk = s; m_run = 1; end
    end else if (s == m_rk) begin
      m_run++;
    end else begin
      m_run = 0;
    end
    if (!m_acc && m_run == FILT) begin
      m_acc = 1'b1; m_ak = m_rk; m_skip = 1'b1; m_rel = 0; m_run = 0;
      m_req = 1'b1; m_wrt = (m_ak == KW); m_adr = sm; m_dbo = sd;
      if (m_ak == KR) m_cap = RDL;
      exp_q.push_back({m_wrt, m_adr, m_dbo});
    end
    m_busy = m_acc || (m_run > 0);
  endtask

  // Monitor + scoreboard: pins sampled on the edge, outputs compared 1 time unit later.
  always begin
    logic [10:0] exp_acc;
    @(posedge clk_w);
    edge_cnt++;
    if (!reset_n_w) model_reset();
    else model_step(pin_kind(csr_n, csw_n), mode, cdo, vdp_dbi);
    #1;
    check_eq("req", cpu_req, m_req);
    check_eq("wrt", cpu_wrt, m_wrt);
    check_eq("adr", cpu_adr, {14'd0, m_adr});
    check_eq("dbo", cpu_dbo, m_dbo);
    check_eq("cdi", cdi, m_cdi);
    check_eq("busy", busy, m_busy);
    check_eq("dbg_busy", state_dbg != vdp_bus_pkg::ST_IDLE, m_busy);
    check_eq("proto_err", proto_err, m_perr);
    if (busy) busy_seen = 1'b1;
    if (cpu_req) begin
      pulse_cnt++;
      last_req_edge = edge_cnt;
      check_eq("sb_unexpected_req", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_acc = exp_q.pop_front();
        check_eq("sb_access", {cpu_wrt, cpu_adr[1:0], cpu_dbo}, exp_acc);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_w);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_pins(input logic r_n, input logic w_n, input logic [1:0] m,
                          input logic [7:0] d);
    csr_n = r_n; csw_n = w_n; mode = m; cdo = d;
  endtask

  int e0, p0;

  initial begin
    int k, len;
    model_reset();
    reset_n_w = 1'b0;
    set_pins(1'b1, 1'b1, 2'd0, 8'd0);
    vdp_dbi = 8'h00;
    ticks(3);
    reset_n_w = 1'b1;
    ticks(4);
    check_eq("rst_cdi", cdi, 8'hFF);

    // write access, long strobe, mode/cdo change after the pulse
    set_pins(1'b1, 1'b0, 2'd1, 8'hA5);
    e0 = edge_cnt; p0 = pulse_cnt;
    ticks(10);
    mode = 2'd2; cdo = 8'h5A;
    ticks(10);
    check_eq("t1_req_edge", last_req_edge - e0, 5);
    check_eq("t1_pulses", pulse_cnt - p0, 1);
    check_eq("t1_adr", cpu_adr, 16'h0001);
    check_eq("t1_dbo", cpu_dbo, 8'hA5);
    csw_n = 1'b1;
    ticks(4);
    check_eq("t1_busy_hold", busy, 1);
    tick();
    check_eq("t1_busy_rel", busy, 0);
    ticks(2);

    // read access and capture
    vdp_dbi = 8'h3C;
    set_pins(1'b0, 1'b1, 2'd0, 8'h00);
    e0 = edge_cnt; p0 = pulse_cnt;
    ticks(6);
    check_eq("t2_cdi_before", cdi, 8'hFF);
    tick();
    check_eq("t2_cdi_cap", cdi, 8'h3C);
    check_eq("t2_req_edge", last_req_edge - e0, 5);
    ticks(3);
    csr_n = 1'b1; vdp_dbi = 8'h99;
    ticks(8);
    check_eq("t2_cdi_hold", cdi, 8'h3C);
    check_eq("t2_pulses", pulse_cnt - p0, 1);

    // glitch
    busy_seen = 1'b0; p0 = pulse_cnt;
    set_pins(1'b1, 1'b0, 2'd3, 8'h11);
    ticks(2);
    csw_n = 1'b1;
    ticks(8);
    check_eq("t3_pulses", pulse_cnt - p0, 0);
    check_eq("t3_busy_seen", busy_seen, 1);
    check_eq("t3_busy", busy, 0);
    check_eq("t3_proto_err", proto_err, 0);

    // spacing: short release merges, FILT+ release separates
    p0 = pulse_cnt;
    csw_n = 1'b0; ticks(10); csw_n = 1'b1; ticks(2);
    csw_n = 1'b0; ticks(10); csw_n = 1'b1; ticks(8);
    check_eq("t4_merged", pulse_cnt - p0, 1);
    p0 = pulse_cnt;
    csw_n = 1'b0; ticks(10); csw_n = 1'b1; ticks(4);
    csw_n = 1'b0; ticks(10); csw_n = 1'b1; ticks(8);
    check_eq("t4_split", pulse_cnt - p0, 2);

    // both strobes low
    p0 = pulse_cnt;
    set_pins(1'b0, 1'b0, 2'd1, 8'h22);
    ticks(5);
    set_pins(1'b1, 1'b1, 2'd1, 8'h22);
    ticks(8);
    check_eq("t5_pulses", pulse_cnt - p0, 0);
    check_eq("t5_proto_err", proto_err, 1);
    p0 = pulse_cnt;
    csw_n = 1'b0; ticks(6); csw_n = 1'b1; ticks(8);
    check_eq("t5_valid_pulse", pulse_cnt - p0, 1);
    check_eq("t5_sticky", proto_err, 1);

    // async reset in the middle of qualification
    set_pins(1'b1, 1'b0, 2'd1, 8'hC3);
    ticks(3);
    reset_n_w = 1'b0;
    #1;
    check_eq("t6_req", cpu_req, 0);
    check_eq("t6_wrt", cpu_wrt, 0);
    check_eq("t6_adr", cpu_adr, 16'h0000);
    check_eq("t6_dbo", cpu_dbo, 8'h00);
    check_eq("t6_cdi", cdi, 8'hFF);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_proto_err", proto_err, 0);
    ticks(2);
    reset_n_w = 1'b1;
    e0 = edge_cnt; p0 = pulse_cnt;
    ticks(10);
    check_eq("t6_req_edge", last_req_edge - e0, 5);
    check_eq("t6_pulses", pulse_cnt - p0, 1);
    check_eq("t6_cdi_after", cdi, 8'hFF);
    csw_n = 1'b1;
    ticks(8);

    // random strobe traffic with changing mode/cdo/dbi every cycle
    for (int seg = 0; seg < 80; seg++) begin
      k   = $urandom_range(0, 9);
      len = $urandom_range(1, 9);
      if (k <= 3)      begin csr_n = 1'b1; csw_n = 1'b1; end
      else if (k <= 6) begin csr_n = 1'b1; csw_n = 1'b0; end
      else if (k <= 8) begin csr_n = 1'b0; csw_n = 1'b1; end
      else             begin csr_n = 1'b0; csw_n = 1'b0; end
      for (int c = 0; c < len; c++) begin
        mode    = 2'($urandom_range(0, 3));
        cdo     = 8'($urandom_range(0, 255));
        vdp_dbi = 8'($urandom_range(0, 255));
        tick();
      end
    end
    csr_n = 1'b1; csw_n = 1'b1;
    ticks(12);
    check_eq("end_busy", busy, 0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
